// File: rtl/i2c_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_frame_pkg
// Description : Shared definitions for the I2C frame sequencer.
//               Holds the FSM state encoding, the default slave address,
//               and a helper that returns the counter width for a given
//               terminal value.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_frame_pkg;

    // Frame sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_CMD = 3'd1,
        S_SEND_BYTE = 3'd2,
        S_WAIT      = 3'd3,
        S_STOP_CMD  = 3'd4,
        S_STOP_WAIT = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    // Address byte sent with START on the player board link.
    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'hAA;

    // Width of a counter that must hold values 0..max_val inclusive.
    // Never returns less than 1 so a zero terminal value still yields a
    // legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : i2c_frame_pkg
`default_nettype wire

// File: rtl/i2c_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : i2c_frame_sender
// Description : Sequences one I2C write frame through a byte-level master:
//               START+address, NUM_BYTES payload bytes, STOP. Detects NACK
//               and re-attempts the whole frame up to MAX_RETRY times using
//               the payload captured at trigger time. An abort always ends
//               with a STOP so the bus is released.
//
// Ports       : clk          - clock
//               reset        - asynchronous, active-high
//               send_trigger - one-cycle frame request (ignored while busy)
//               payload      - frame data, byte k at [8k+7:8k], byte 0 first
//               abort        - level, terminates the current frame
//               ready        - master idle / accepting a command
//               ack_err      - master NACK flag, valid as ready rises
//               start        - START command (tx_data = SLAVE_ADDR)
//               stop         - STOP command
//               i2c_en       - command valid
//               tx_data      - byte for the current command
//               busy         - frame in progress
//               done         - one-cycle pulse, frame completed with ACKs
//               error        - one-cycle pulse, retries exhausted or aborted
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_frame_sender
    import i2c_frame_pkg::*;
#(
    parameter int         NUM_BYTES  = 5,
    parameter logic [7:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send_trigger,
    input  logic [NUM_BYTES*8-1:0] payload,
    input  logic                   abort,
    input  logic                   ready,
    input  logic                   ack_err,
    output logic                   start,
    output logic                   stop,
    output logic                   i2c_en,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int IDX_W   = cnt_width(NUM_BYTES);
    localparam int RETRY_W = cnt_width(MAX_RETRY);

    // Terminal values cast to counter width so compares stay width-matched.
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NUM_BYTES);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    state_t                   state_q,      state_d;
    logic [IDX_W-1:0]         byte_idx_q,   byte_idx_d;
    logic [RETRY_W-1:0]       retry_cnt_q,  retry_cnt_d;
    logic [NUM_BYTES*8-1:0]   payload_q,    payload_d;
    logic                     nack_flag_q,  nack_flag_d;
    logic                     abort_flag_q, abort_flag_d;
    logic                     error_q,      error_d;

    logic [IDX_W+2:0]         byte_base;
    logic [7:0]               cur_byte;

    // Bit offset of the current byte within the latched payload.
    assign byte_base = {byte_idx_q, 3'b000};
    assign cur_byte  = payload_q[byte_base +: 8];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            retry_cnt_q  <= '0;
            payload_q    <= '0;
            nack_flag_q  <= 1'b0;
            abort_flag_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            retry_cnt_q  <= retry_cnt_d;
            payload_q    <= payload_d;
            nack_flag_q  <= nack_flag_d;
            abort_flag_q <= abort_flag_d;
            error_q      <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        retry_cnt_d  = retry_cnt_q;
        payload_d    = payload_q;
        nack_flag_d  = nack_flag_q;
        abort_flag_d = abort_flag_q;
        error_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (send_trigger) begin
                    payload_d    = payload;
                    byte_idx_d   = '0;
                    retry_cnt_d  = '0;
                    nack_flag_d  = 1'b0;
                    abort_flag_d = 1'b0;
                    state_d      = S_START_CMD;
                end
            end

            S_START_CMD: begin
                // Once ready has dropped the master owns the bus, so an
                // abort from here on must be finished with a STOP.
                if (!ready) begin
                    state_d = S_WAIT;
                    if (abort) begin
                        abort_flag_d = 1'b1;
                    end
                end else if (abort) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    abort_flag_d = 1'b1;
                end
                if (ready) begin
                    if (ack_err) begin
                        nack_flag_d = 1'b1;
                        state_d     = S_STOP_CMD;
                    end else if (abort_flag_q || abort) begin
                        state_d = S_STOP_CMD;
                    end else if (byte_idx_q < LAST_IDX) begin
                        state_d = S_SEND_BYTE;
                    end else begin
                        state_d = S_STOP_CMD;
                    end
                end
            end

            S_SEND_BYTE: begin
                if (!ready) begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    state_d    = S_WAIT;
                    if (abort) begin
                        abort_flag_d = 1'b1;
                    end
                end else if (abort) begin
                    // Master is idle and has not taken the byte: skip it
                    // and go straight to releasing the bus.
                    abort_flag_d = 1'b1;
                    state_d      = S_STOP_CMD;
                end
            end

            S_STOP_CMD: begin
                if (!ready) begin
                    state_d = S_STOP_WAIT;
                end
            end

            S_STOP_WAIT: begin
                if (ready) begin
                    if (abort_flag_q) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (nack_flag_q && (retry_cnt_q < RETRY_LIMIT)) begin
                        // Re-send from the latched copy; the live payload
                        // input is not looked at again.
                        retry_cnt_d = retry_cnt_q + 1'b1;
                        nack_flag_d = 1'b0;
                        byte_idx_d  = '0;
                        state_d     = S_START_CMD;
                    end else if (nack_flag_q) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: depends on registered state only)
    // ------------------------------------------------------------------
    always_comb begin
        start   = 1'b0;
        stop    = 1'b0;
        i2c_en  = 1'b0;
        tx_data = 8'h00;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        error   = error_q;

        case (state_q)
            S_START_CMD: begin
                start   = 1'b1;
                i2c_en  = 1'b1;
                tx_data = SLAVE_ADDR;
            end
            S_SEND_BYTE: begin
                i2c_en  = 1'b1;
                tx_data = cur_byte;
            end
            S_STOP_CMD: begin
                stop    = 1'b1;
                i2c_en  = 1'b1;
            end
            default: begin
                start   = 1'b0;
            end
        endcase
    end

endmodule : i2c_frame_sender
`default_nettype wire

// File: tb/tb_i2c_frame_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_frame_sender
// Description : Self-checking bench for i2c_frame_sender. A behavioural
//               byte master accepts commands and compares each against a
//               queue of expected commands filled when a frame is launched.
//               A second instance with NUM_BYTES=1 shares the master model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_frame_sender;
    import i2c_frame_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        trig0 = 1'b0;
    logic        trig1 = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b1;
    logic        ack_err = 1'b0;
    logic        sel = 1'b0;
    logic [39:0] payload0 = '0;
    logic [7:0]  payload1 = '0;

    logic       start0, stop0, en0, busy0, done0, err0;
    logic [7:0] tx0;
    logic       start1, stop1, en1, busy1, done1, err1;
    logic [7:0] tx1;

    logic       m_start, m_stop, m_en, m_busy, m_done, m_err;
    logic [7:0] m_tx;

    assign m_start = sel ? start1 : start0;
    assign m_stop  = sel ? stop1  : stop0;
    assign m_en    = sel ? en1    : en0;
    assign m_busy  = sel ? busy1  : busy0;
    assign m_done  = sel ? done1  : done0;
    assign m_err   = sel ? err1   : err0;
    assign m_tx    = sel ? tx1    : tx0;

    i2c_frame_sender #(.NUM_BYTES(5), .SLAVE_ADDR(8'hAA), .MAX_RETRY(2)) dut (
        .clk(clk), .reset(reset), .send_trigger(trig0), .payload(payload0),
        .abort(abort), .ready(ready), .ack_err(ack_err),
        .start(start0), .stop(stop0), .i2c_en(en0), .tx_data(tx0),
        .busy(busy0), .done(done0), .error(err0)
    );

    i2c_frame_sender #(.NUM_BYTES(1), .SLAVE_ADDR(8'hAA), .MAX_RETRY(2)) dut1 (
        .clk(clk), .reset(reset), .send_trigger(trig1), .payload(payload1),
        .abort(abort), .ready(ready), .ack_err(ack_err),
        .start(start1), .stop(stop1), .i2c_en(en1), .tx_data(tx1),
        .busy(busy1), .done(done1), .error(err1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected command stream: {start, stop, tx_data}
    logic [9:0] sb[$];
    int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
    int attempt = 0, cmd_idx = 0, lat = 0;
    int nack_cmd = -1, nack_attempts = 0;
    logic pending_nack = 1'b0;

    // Byte master model: accepts a command when idle, stays busy a few
    // cycles, then raises ready with its ACK/NACK result for one cycle.
    always @(negedge clk) begin
        logic [9:0] rec;
        if (m_done) done_cnt++;
        if (m_err)  err_cnt++;
        if (reset) begin
            ready   = 1'b1;
            ack_err = 1'b0;
            lat     = 0;
        end else begin
            ack_err = 1'b0;
            if (!ready) begin
                if (lat == 0) begin
                    ready   = 1'b1;
                    ack_err = pending_nack;
                end else begin
                    lat--;
                end
            end else if (m_en) begin
                rec = {m_start, m_stop, m_tx};
                acc_cnt++;
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                else chk($sformatf("cmd%0d", acc_cnt), 32'(rec), 32'(sb.pop_front()));
                pending_nack = 1'b0;
                if (m_start) begin
                    attempt++;
                    pending_nack = (attempt <= nack_attempts) && (nack_cmd == 0);
                    cmd_idx = 1;
                end else if (!m_stop) begin
                    pending_nack = (attempt <= nack_attempts) && (cmd_idx == nack_cmd);
                    cmd_idx++;
                end
                ready = 1'b0;
                lat   = 2;
            end
        end
    end

    task automatic push_start();
        sb.push_back({2'b10, 8'hAA});
    endtask
    task automatic push_stop();
        sb.push_back({2'b01, 8'h00});
    endtask
    task automatic push_bytes(input logic [39:0] p, input int n);
        logic [39:0] v;
        v = p;
        for (int k = 0; k < n; k++) begin
            sb.push_back({2'b00, v[8*k +: 8]});
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk);
        if (sel) trig1 = 1'b1; else trig0 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        trig0 = 1'b0;
    endtask

    task automatic wait_acc(input int target);
        int n;
        n = 0;
        while (acc_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("wait_acc_timeout", 32'(n < 500), 32'd1);
    endtask

    task automatic run_frame(input string tag, input int exp_done, input int exp_err);
        int n;
        done_cnt = 0;
        err_cnt  = 0;
        attempt  = 0;
        pulse_trigger();
        n = 0;
        while (m_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 2000), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_err"},  32'(err_cnt),  32'(exp_err));
        chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    localparam logic [39:0] P_A = {8'h00, 8'h01, 8'h03, 8'h7F, 8'h40};

    initial begin
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({start0, stop0, en0, tx0, busy0, done0, err0}), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", 32'({start0, stop0, en0, tx0, busy0, done0, err0}), 32'd0);

        // Plain five-byte frame, all ACK
        payload0 = P_A;
        push_start(); push_bytes(P_A, 5); push_stop();
        run_frame("basic", 1, 0);

        // NACK on data byte 2, recovered on the second attempt
        nack_cmd = 3; nack_attempts = 1;
        push_start(); push_bytes(P_A, 3); push_stop();
        push_start(); push_bytes(P_A, 5); push_stop();
        run_frame("nack_retry", 1, 0);
        chk("retry_cnt", 32'(dut.retry_cnt_q), 32'd1);

        // Address NACK on every attempt: three STARTs then error
        nack_cmd = 0; nack_attempts = 99;
        for (int i = 0; i < 3; i++) begin
            push_start(); push_stop();
        end
        run_frame("nack_exhaust", 0, 1);
        nack_cmd = -1; nack_attempts = 0;

        // Abort while waiting after byte 1
        base = acc_cnt;
        push_start(); push_bytes(P_A, 2); push_stop();
        fork
            run_frame("abort", 0, 1);
            begin
                wait_acc(base + 3);
                @(negedge clk);
                abort = 1'b1;
            end
        join
        abort = 1'b0;
        chk("abort_busy", 32'(m_busy), 32'd0);

        // Trigger with new payload while busy is dropped
        base = acc_cnt;
        push_start(); push_bytes(P_A, 5); push_stop();
        fork
            run_frame("busy_trig", 1, 0);
            begin
                wait_acc(base + 2);
                payload0 = {5{8'h11}};
                @(negedge clk); trig0 = 1'b1;
                @(negedge clk); trig0 = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        chk("no_requeue", 32'(m_busy), 32'd0);
        payload0 = P_A;

        // Single-byte instance
        sel = 1'b1;
        payload1 = 8'h5A;
        push_start(); push_bytes({32'h0, 8'h5A}, 1); push_stop();
        run_frame("one_byte", 1, 0);
        sel = 1'b0;

        // Asynchronous reset in the middle of a byte
        base = acc_cnt;
        push_start(); push_bytes(P_A, 5); push_stop();
        pulse_trigger();
        wait_acc(base + 2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_outs", 32'({start0, stop0, en0, tx0, busy0, done0, err0}), 32'd0);
        chk("midrst_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("midrst_idx", 32'(dut.byte_idx_q), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Recovery after reset
        push_start(); push_bytes(P_A, 5); push_stop();
        run_frame("after_rst", 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_i2c_frame_sender
`default_nettype wire
